// File: rtl/iterative_divider_if.sv
// Divide request/response bundle between the execute stage (master) and the divider (slave).
interface iterative_divider_if #(parameter int WIDTH = 64);
  logic             valid_in;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             valid_out;
  logic             busy;

  modport master (
    output valid_in, dividend, divisor,
    input  quotient, remainder, valid_out, busy
  );

  modport slave (
    input  valid_in, dividend, divisor,
    output quotient, remainder, valid_out, busy
  );
endinterface

// File: rtl/iterative_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional macro ITERATIVE_DIVIDER_ZERO_FASTPATH_EN: divide-by-zero skips the iteration.
module iterative_divider #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  iterative_divider_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a request
  // BUSY  | one restoring step per clock, cnt_q counts down to 0
  // DONE  | valid_out pulse, results already on the outputs
  // DRAIN | finished request still high; wait for it to drop
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_out_q, valid_out_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_q;

  // rem < divisor holds between steps, so a WIDTH-bit subtract of the low bits is exact.
  always_comb begin
    trial    = {rem_q, q_q[WIDTH-1]};
    fits     = (trial >= {1'b0, dvsr_q});
    step_rem = fits ? (trial[WIDTH-1:0] - dvsr_q) : trial[WIDTH-1:0];
    step_q   = {q_q[WIDTH-2:0], fits};
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    q_d         = q_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_in) begin
          rem_d   = '0;
          q_d     = bus.dividend;
          dvsr_d  = bus.divisor;
          cnt_d   = CW'(WIDTH - 1);
          state_d = BUSY;
`ifdef ITERATIVE_DIVIDER_ZERO_FASTPATH_EN
          if (bus.divisor == '0) begin
            quotient_d  = '1;
            remainder_d = bus.dividend;
            state_d     = DONE;
          end
`endif
        end
      end
      BUSY: begin
        rem_d = step_rem;
        q_d   = step_q;
        if (cnt_q == '0) begin
          quotient_d  = step_q;
          remainder_d = step_rem;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = bus.valid_in ? DRAIN : IDLE;
      DRAIN:   if (!bus.valid_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    valid_out_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      q_q         <= '0;
      dvsr_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      valid_out_q <= valid_out_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.valid_out = valid_out_q;
  assign bus.busy      = busy_q;
endmodule
